// File: rtl/dict_compressor_if.sv
// Stream-side bundle for dict_compressor: input word handshake, flush pulse and
// packed output handshake. master = source/sink side, slave = the compressor.
interface dict_compressor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/dict_compressor.sv
// Adaptive round-robin dictionary compressor: emits LSB-first match/miss tokens.
// Optional macro STATS_EN adds saturating hit/miss counters (stat_hits, stat_misses).
module dict_compressor #(
    parameter int WIDTH      = 32,
    parameter int DICT_DEPTH = 16,
    parameter int IDX_BITS   = 4
) (
    input  logic clk,
    input  logic reset,
    dict_compressor_if.slave bus
`ifdef STATS_EN
    ,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
`endif
);
    localparam int BUF_W  = 3 * WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FLUSH       = 2'd1,
        FLUSH_EMPTY = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [WIDTH-1:0]      dict_q [DICT_DEPTH];
    logic [WIDTH-1:0]      dict_d [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] valid_q, valid_d;
    logic [IDX_BITS-1:0]   ptr_q, ptr_d;

    logic                  in_ready_s, out_valid_s, out_last_s, pop_s, accept_s, clear_s;
    logic [DICT_DEPTH-1:0] match_vec_s;
    logic                  hit_s;
    logic [IDX_BITS-1:0]   hit_idx_s;
    logic [WIDTH:0]        tok_s;
    logic [FILL_W-1:0]     tok_len_s;

    assign in_ready_s  = (state_q == RUN) && (fill_q <= FILL_W'(2 * WIDTH - 1));
    assign out_valid_s = (fill_q >= FILL_W'(WIDTH))
                       || ((state_q == FLUSH) && (fill_q != '0))
                       || (state_q == FLUSH_EMPTY);
    assign out_last_s  = ((state_q == FLUSH) && (fill_q != '0) && (fill_q <= FILL_W'(WIDTH)))
                       || (state_q == FLUSH_EMPTY);
    assign pop_s       = out_valid_s && bus.out_ready;
    assign accept_s    = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_last  = out_last_s;
    assign bus.out_data  = buf_q[WIDTH-1:0];

    // Parallel dictionary lookup; descending scan so the lowest matching index wins.
    always_comb begin
        hit_idx_s = '0;
        for (int i = 0; i < DICT_DEPTH; i++) begin
            match_vec_s[i] = valid_q[i] && (dict_q[i] == bus.in_data);
        end
        for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
            hit_idx_s = match_vec_s[i] ? IDX_BITS'(i) : hit_idx_s;
        end
        hit_s     = |match_vec_s;
        tok_s     = hit_s ? {{(WIDTH - IDX_BITS){1'b0}}, hit_idx_s, 1'b1} : {bus.in_data, 1'b0};
        tok_len_s = hit_s ? FILL_W'(IDX_BITS + 1) : FILL_W'(WIDTH + 1);
    end

    // Next-state: pop first, then append the new token behind what remains.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        dict_d  = dict_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        clear_s = 1'b0;
        if (pop_s) begin
            buf_d  = buf_q >> WIDTH;
            fill_d = (fill_q >= FILL_W'(WIDTH)) ? (fill_q - FILL_W'(WIDTH)) : '0;
        end else begin
            buf_d  = buf_q;
            fill_d = fill_q;
        end
        if (accept_s) begin
            buf_d  = buf_d | (BUF_W'(tok_s) << fill_d);
            fill_d = fill_d + tok_len_s;
            if (!hit_s) begin
                dict_d[ptr_q]  = bus.in_data;
                valid_d[ptr_q] = 1'b1;
                ptr_d          = ptr_q + IDX_BITS'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d = (fill_d != '0) ? FLUSH : FLUSH_EMPTY;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (pop_s && (fill_d == '0)) begin
                    state_d = RUN;
                    clear_s = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            FLUSH_EMPTY: begin
                if (pop_s) begin
                    state_d = RUN;
                    clear_s = 1'b1;
                end else begin
                    state_d = FLUSH_EMPTY;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Each block starts with a cold dictionary.
        if (clear_s) begin
            valid_d = '0;
            ptr_d   = '0;
        end else begin
            ptr_d = ptr_d;
        end
    end

    // State, bit buffer and dictionary registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            buf_q   <= '0;
            fill_q  <= '0;
            dict_q  <= '{default: '0};
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            dict_q  <= dict_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef STATS_EN
    logic [15:0] hits_q, hits_d, misses_q, misses_d;

    // Saturating token counters, cleared when a block ends.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (clear_s) begin
            hits_d   = 16'd0;
            misses_d = 16'd0;
        end else if (accept_s && hit_s && (hits_q != 16'hFFFF)) begin
            hits_d = hits_q + 16'd1;
        end else if (accept_s && !hit_s && (misses_q != 16'hFFFF)) begin
            misses_d = misses_q + 16'd1;
        end else begin
            hits_d = hits_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= 16'd0;
            misses_q <= 16'd0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_dict_compressor.sv
// Directed bench for dict_compressor: bit-queue reference model checked every cycle,
// plus hand-computed word/token expectations per scenario.
module tb_dict_compressor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    dict_compressor_if #(.WIDTH(32)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.flush     = flush;
    assign bus.out_ready = out_ready;

`ifdef STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    dict_compressor #(.WIDTH(32), .DICT_DEPTH(16), .IDX_BITS(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef STATS_EN
        ,
        .stat_hits(stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending bits as a queue, dictionary as arrays.
    bit          mq[$];
    logic [31:0] mdict[16];
    bit          mval[16];
    int          mptr;
    int          mmode;            // 0 run, 1 draining, 2 empty-flush word
    logic [32:0] mlog[$];
    logic [32:0] dlog[$];
    int          tlog[$];          // -1 miss, else matched index

    function automatic bit m_valid();
        return (mq.size() >= 32) || (mmode == 1 && mq.size() > 0) || (mmode == 2);
    endfunction
    function automatic bit m_ready();
        return (mmode == 0) && (mq.size() <= 63);
    endfunction
    function automatic logic [31:0] m_word();
        logic [31:0] w = 32'd0;
        for (int b = 0; b < 32; b++) w[b] = (b < mq.size()) ? mq[b] : 1'b0;
        return w;
    endfunction
    function automatic bit m_last();
        return (mmode == 1 && mq.size() > 0 && mq.size() <= 32) || (mmode == 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int i = 0; i < 16; i++) mval[i] = 1'b0;
            mptr  = 0;
            mmode = 0;
        end else begin
            bit pop, acc;
            int hit;
            pop = m_valid() && out_ready;
            acc = in_valid && m_ready();
            if (pop) begin
                mlog.push_back({m_last(), m_word()});
                for (int k = 0; k < 32 && mq.size() > 0; k++) void'(mq.pop_front());
            end
            if (acc) begin
                hit = -1;
                for (int i = 0; i < 16; i++)
                    if (hit < 0 && mval[i] && mdict[i] == in_data) hit = i;
                tlog.push_back(hit);
                if (hit >= 0) begin
                    mq.push_back(1'b1);
                    for (int b = 0; b < 4; b++) mq.push_back(hit[b]);
                end else begin
                    mq.push_back(1'b0);
                    for (int b = 0; b < 32; b++) mq.push_back(in_data[b]);
                    mdict[mptr] = in_data;
                    mval[mptr]  = 1'b1;
                    mptr        = (mptr + 1) % 16;
                end
            end
            if (mmode == 0) begin
                if (flush) mmode = (mq.size() > 0) ? 1 : 2;
            end else if (pop && (mmode == 2 || mq.size() == 0)) begin
                mmode = 0;
                for (int i = 0; i < 16; i++) mval[i] = 1'b0;
                mptr = 0;
            end
        end
    end

    // Per-cycle comparison against the model, and capture of DUT output words.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", bus.in_ready, m_ready());
            chk("out_valid", bus.out_valid, m_valid());
            if (m_valid()) begin
                chk("out_data", bus.out_data, m_word());
                chk("out_last", bus.out_last, m_last());
            end
            if (bus.out_valid && out_ready) dlog.push_back({bus.out_last, bus.out_data});
        end
    end

    task automatic clear_logs();
        dlog.delete();
        mlog.delete();
        tlog.delete();
    endtask

    task automatic send(input logic [31:0] w);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        bit found = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_last) begin
                found = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("drain_timeout", found, 1'b1);
    endtask

    task automatic expect_words(input logic [32:0] ew[$]);
        chk("dut_word_count", dlog.size(), ew.size());
        chk("model_word_count", mlog.size(), ew.size());
        for (int i = 0; i < ew.size(); i++) begin
            if (i < dlog.size()) chk($sformatf("dut_word%0d", i), dlog[i], ew[i]);
            if (i < mlog.size()) chk($sformatf("model_word%0d", i), mlog[i], ew[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [32:0] ew[$];
        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single miss then flush
        out_ready = 1'b1;
        clear_logs();
        send(32'hDEADBEEF);
        pulse_flush();
        drain();
        ew = {33'h0BD5B7DDE, 33'h100000001};
        expect_words(ew);

        // Miss then match of the same word
        clear_logs();
        send(32'hDEADBEEF);
        send(32'hDEADBEEF);
        pulse_flush();
        drain();
        ew = {33'h0BD5B7DDE, 33'h100000003};
        expect_words(ew);
        chk("t2_tok1_idx", tlog.size() > 1 ? tlog[1] : 99, 0);

        // Round-robin wrap: entry 0 replaced by 0x11
        clear_logs();
        for (int i = 1; i <= 17; i++) send(32'(i));
        send(32'h1);
        send(32'h11);
        pulse_flush();
        drain();
        chk("t3_tok_count", tlog.size(), 19);
        if (tlog.size() == 19) begin
            chk("t3_tok0_miss", tlog[0], -1);
            chk("t3_word1_miss", tlog[17], -1);
            chk("t3_word11_match0", tlog[18], 0);
        end

        // Back-pressure: buffer fills to 66 bits and in_ready drops
        clear_logs();
        out_ready = 1'b0;
        send(32'h11111111);
        send(32'h22222222);
        @(negedge clk);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_out_valid", bus.out_valid, 1'b1);
        chk("bp_out_data", bus.out_data, 32'h22222222);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h33333333);
        pulse_flush();
        drain();
        ew = {33'h022222222, 33'h088888888, 33'h099999998, 33'h100000001};
        expect_words(ew);

        // Empty flush, then a previously seen word is a miss again
        clear_logs();
        send(32'hCAFEF00D);
        pulse_flush();
        drain();
        ew = {33'h095FDE01A, 33'h100000001};
        expect_words(ew);
        clear_logs();
        pulse_flush();
        drain();
        ew = {33'h100000000};
        expect_words(ew);
        clear_logs();
        send(32'hCAFEF00D);
        chk("t5_cold_miss", tlog.size() > 0 ? tlog[0] : 99, -1);
        pulse_flush();
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h12345678);
        send(32'h9ABCDEF0);
        @(negedge clk);
        chk("pre_rst_out_valid", bus.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 1'b0);
        chk("async_rst_out_data", bus.out_data, 32'h0);
        chk("async_rst_out_last", bus.out_last, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_logs();
        out_ready = 1'b1;
        send(32'hDEADBEEF);
        pulse_flush();
        drain();
        ew = {33'h0BD5B7DDE, 33'h100000001};
        expect_words(ew);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
